// File: rtl/hack_datapath_pkg.sv
// Shared definitions for the Hack datapath: default width, alu_ctrl bit
// positions and the commonly used alu_ctrl encodings.
package hack_datapath_pkg;

  localparam int unsigned HACK_WIDTH = 16;

  // Bit positions within alu_ctrl = {zx,nx,zy,ny,f,no}
  localparam int unsigned CTRL_ZX = 5;
  localparam int unsigned CTRL_NX = 4;
  localparam int unsigned CTRL_ZY = 3;
  localparam int unsigned CTRL_NY = 2;
  localparam int unsigned CTRL_F  = 1;
  localparam int unsigned CTRL_NO = 0;

  localparam logic [5:0] ADD       = 6'b000010;
  localparam logic [5:0] AND       = 6'b000000;
  localparam logic [5:0] X_MINUS_Y = 6'b010011;
  localparam logic [5:0] ZERO      = 6'b101010;
  localparam logic [5:0] ONE       = 6'b111111;
  localparam logic [5:0] NEG_ONE   = 6'b111010;

endpackage

// File: rtl/hack_datapath_alu.sv
// Purely combinational Hack ALU: operand zero/negate, add or and,
// optional output negate, plus zero and negative flags.
module hack_alu
  import hack_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = HACK_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] x1, x2, y1, y2, r;

  always_comb begin
    x1  = ctrl[CTRL_ZX] ? '0 : x;
    x2  = ctrl[CTRL_NX] ? ~x1 : x1;
    y1  = ctrl[CTRL_ZY] ? '0 : y;
    y2  = ctrl[CTRL_NY] ? ~y1 : y1;
    r   = ctrl[CTRL_F] ? (x2 + y2) : (x2 & y2);
    out = ctrl[CTRL_NO] ? ~r : r;
  end

  assign zr = (out == '0);
  assign ng = out[WIDTH-1];

endmodule

// File: rtl/hack_datapath.sv
// Hack CPU datapath slice: combinational ALU plus independent A, D and PC
// registers; all routing between them is left to the parent.
module hack_datapath
  import hack_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = HACK_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_x,
  input  logic [WIDTH-1:0] alu_y,
  input  logic [5:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_zr,
  output logic             alu_ng,
  input  logic [WIDTH-1:0] a_in,
  input  logic             a_load,
  output logic [WIDTH-1:0] a_out,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_load,
  output logic [WIDTH-1:0] d_out,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             pc_load,
  input  logic             pc_inc,
  input  logic             pc_clr,
  output logic [WIDTH-1:0] pc_out
);

  logic [WIDTH-1:0] a_reg, d_reg, pc_reg;

  hack_alu #(.WIDTH(WIDTH)) u_alu (
    .x    (alu_x),
    .y    (alu_y),
    .ctrl (alu_ctrl),
    .out  (alu_out),
    .zr   (alu_zr),
    .ng   (alu_ng)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg <= '0;
    end else if (a_load) begin
      a_reg <= a_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_reg <= '0;
    end else if (d_load) begin
      d_reg <= d_in;
    end
  end

  // Synchronous clear outranks load, which outranks increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg <= '0;
    end else if (pc_clr) begin
      pc_reg <= '0;
    end else if (pc_load) begin
      pc_reg <= pc_in;
    end else if (pc_inc) begin
      pc_reg <= pc_reg + WIDTH'(1);
    end
  end

  assign a_out  = a_reg;
  assign d_out  = d_reg;
  assign pc_out = pc_reg;

endmodule

// File: tb/tb_hack_datapath.sv
// Scoreboard bench for hack_datapath: a driver pushes expected responses
// from an arithmetic reference model, a monitor pops and compares.
module tb_hack_datapath;
  import hack_datapath_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] alu_x, alu_y, alu_out;
  logic [5:0]  alu_ctrl;
  logic        alu_zr, alu_ng;
  logic [15:0] a_in, a_out, d_in, d_out, pc_in, pc_out;
  logic        a_load, d_load, pc_load, pc_inc, pc_clr;

  hack_datapath #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_x    (alu_x),
    .alu_y    (alu_y),
    .alu_ctrl (alu_ctrl),
    .alu_out  (alu_out),
    .alu_zr   (alu_zr),
    .alu_ng   (alu_ng),
    .a_in     (a_in),
    .a_load   (a_load),
    .a_out    (a_out),
    .d_in     (d_in),
    .d_load   (d_load),
    .d_out    (d_out),
    .pc_in    (pc_in),
    .pc_load  (pc_load),
    .pc_inc   (pc_inc),
    .pc_clr   (pc_clr),
    .pc_out   (pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] alu;
    logic        zr;
    logic        ng;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] pc;
    string       tag;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state
  int m_a = 0, m_d = 0, m_pc = 0;

  function automatic int ref_alu(int x, int y, logic [5:0] c);
    int x2, y2, r;
    x2 = c[5] ? 0 : x;
    if (c[4]) x2 = 65535 - x2;
    y2 = c[3] ? 0 : y;
    if (c[2]) y2 = 65535 - y2;
    r = c[1] ? (x2 + y2) % 65536 : (x2 & y2);
    if (c[0]) r = 65535 - r;
    return r;
  endfunction

  function automatic txn_t make_txn(string tag);
    txn_t t;
    int   r;
    r     = ref_alu(int'(alu_x), int'(alu_y), alu_ctrl);
    t.alu = 16'(r);
    t.zr  = (r == 0);
    t.ng  = (r >= 32768);
    t.a   = 16'(m_a);
    t.d   = 16'(m_d);
    t.pc  = 16'(m_pc);
    t.tag = tag;
    return t;
  endfunction

  task automatic check(string name, string tag, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%04h expected 0x%04h at %0t", tag, name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are sampled 1ns after each clock edge and after any
  // asynchronous reset assertion.
  initial begin
    txn_t t;
    forever begin
      @(posedge clk or negedge reset);
      #1;
      if (exp_q.size() > 0) begin
        t = exp_q.pop_front();
        check("alu_out", t.tag, alu_out, t.alu);
        check("alu_zr",  t.tag, {15'd0, alu_zr}, {15'd0, t.zr});
        check("alu_ng",  t.tag, {15'd0, alu_ng}, {15'd0, t.ng});
        check("a_out",   t.tag, a_out,  t.a);
        check("d_out",   t.tag, d_out,  t.d);
        check("pc_out",  t.tag, pc_out, t.pc);
      end
    end
  end

  task automatic cycle(input logic rst, input logic [15:0] x, input logic [15:0] y,
                       input logic [5:0] ctrl,
                       input logic [15:0] ai, input logic al,
                       input logic [15:0] di, input logic dl,
                       input logic [15:0] pi, input logic pl, input logic pinc,
                       input logic pclr, input string tag);
    @(negedge clk);
    reset = rst; alu_x = x; alu_y = y; alu_ctrl = ctrl;
    a_in = ai; a_load = al; d_in = di; d_load = dl;
    pc_in = pi; pc_load = pl; pc_inc = pinc; pc_clr = pclr;
    if (!rst) begin
      m_a = 0; m_d = 0; m_pc = 0;
    end else begin
      if (al) m_a = int'(ai);
      if (dl) m_d = int'(di);
      if (pclr)      m_pc = 0;
      else if (pl)   m_pc = int'(pi);
      else if (pinc) m_pc = (m_pc + 1) % 65536;
    end
    exp_q.push_back(make_txn(tag));
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    m_a = 0; m_d = 0; m_pc = 0;
    exp_q.push_back(make_txn("async_rst"));
    reset = 1'b0;
  endtask

  initial begin
    logic [5:0] ops [6];
    int wait_cycles;
    ops = '{ADD, AND, X_MINUS_Y, ZERO, ONE, NEG_ONE};
    reset = 1'b0;
    alu_x = '0; alu_y = '0; alu_ctrl = '0;
    a_in = '0; a_load = 1'b0; d_in = '0; d_load = 1'b0;
    pc_in = '0; pc_load = 1'b0; pc_inc = 1'b0; pc_clr = 1'b0;
    repeat (2) @(posedge clk);

    //        rst x        y        ctrl       a_in     al  d_in     dl  pc_in    pl  inc clr
    cycle(0, 16'd5,   16'd3, ADD,       16'h1111, 1, 16'h2222, 1, 16'h3333, 1, 1, 0, "rst_hold");
    cycle(1, 16'd5,   16'd3, ADD,       16'h1234, 1, 16'h00AB, 1, 16'h0010, 1, 0, 0, "load_all");
    cycle(1, 16'd5,   16'd3, X_MINUS_Y, 16'hBEEF, 0, 16'h5555, 0, 16'h0000, 0, 1, 0, "x_minus_y");
    cycle(1, 16'd5,   16'd3, AND,       16'hBEEF, 0, 16'h5555, 0, 16'h0000, 0, 1, 0, "and");
    cycle(1, 16'd5,   16'd3, NEG_ONE,   16'hBEEF, 0, 16'h5555, 0, 16'h0000, 0, 1, 0, "neg_one");
    cycle(1, 16'd5,   16'd3, ZERO,      16'hBEEF, 0, 16'h00CD, 1, 16'hFFFF, 1, 0, 0, "zero_pcmax");
    cycle(1, 16'h7FFF, 16'd1, ADD,      16'hBEEF, 0, 16'h5555, 0, 16'h0000, 0, 1, 0, "ovf_wrap");
    cycle(1, 16'd9,   16'd4, ONE,       16'hBEEF, 0, 16'h5555, 0, 16'h0055, 1, 1, 1, "clr_prio");
    cycle(1, 16'd9,   16'd4, ADD,       16'hBEEF, 0, 16'h5555, 0, 16'h0040, 1, 1, 0, "load_prio");
    async_reset();
    cycle(0, 16'd9,   16'd4, ADD,       16'hBEEF, 0, 16'h5555, 0, 16'h0000, 0, 1, 0, "rst_inc");
    cycle(1, 16'd9,   16'd4, ADD,       16'hBEEF, 0, 16'h5555, 0, 16'h0000, 0, 1, 0, "post_rst");

    for (int i = 0; i < 300; i++) begin
      logic [5:0] c;
      c = ($urandom_range(0, 1) == 0) ? ops[$urandom_range(0, 5)] : 6'($urandom);
      cycle(1, 16'($urandom), 16'($urandom), c,
            16'($urandom), 1'($urandom), 16'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
            ($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 15) == 0),
            "random");
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 50) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_datapath.md
HACK_DATAPATH -- requirements
Module: hack_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the data width of the ALU, the A and D registers and the PC.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port alu_x, input, WIDTH: ALU x operand.
REQ-005 SHALL have port alu_y, input, WIDTH: ALU y operand.
REQ-006 SHALL have port alu_ctrl, input, 6 bits: {zx,nx,zy,ny,f,no}, with zx in bit 5.
REQ-007 SHALL have port alu_out, output, WIDTH: ALU result.
REQ-008 SHALL have port alu_zr, output, 1 bit: high when alu_out is zero.
REQ-009 SHALL have port alu_ng, output, 1 bit: alu_out MSB (negative flag).
REQ-010 SHALL have ports a_in (input, WIDTH), a_load (input, 1) and a_out (output, WIDTH) for the A register.
REQ-011 SHALL have ports d_in (input, WIDTH), d_load (input, 1) and d_out (output, WIDTH) for the D register.
REQ-012 SHALL have ports pc_in (input, WIDTH), pc_load (input, 1), pc_inc (input, 1) and pc_clr (input, 1, synchronous clear) for the PC.
REQ-013 SHALL have port pc_out, output, WIDTH: the current PC value.

Function
REQ-014 SHALL pre-process the ALU x operand: x1 = zx ? 0 : alu_x, then x2 = nx ? ~x1 : x1.
REQ-015 SHALL pre-process the ALU y operand identically using zy and ny.
REQ-016 SHALL compute r = f ? (x2 + y2) mod 2^WIDTH : (x2 & y2), discarding the carry out.
REQ-017 SHALL drive alu_out = no ? ~r : r.
REQ-018 SHALL make the ALU purely combinational, with zero latency and no clock dependence.
REQ-019 SHALL drive alu_zr = (alu_out == 0) and alu_ng = alu_out[WIDTH-1], combinationally.
REQ-020 SHALL capture a_in into A on the rising edge of clk when a_load=1, and otherwise hold A.
REQ-021 SHALL capture d_in into D on the rising edge of clk when d_load=1, and otherwise hold D.
REQ-022 SHALL drive a_out and d_out directly from the register contents, so a new value is visible the cycle after the load edge.
REQ-023 SHALL update the PC on each rising edge of clk with priority pc_clr (PC=0) > pc_load (PC=pc_in) > pc_inc (PC=PC+1) > hold.
REQ-024 SHALL wrap the PC increment modulo 2^WIDTH (0xFFFF+1 = 0x0000 when WIDTH=16).
REQ-025 SHALL keep the A, D and PC registers independent, so simultaneous loads of all three within one cycle all take effect.
REQ-026 SHALL contain no internal path from alu_out to any register; all inter-unit routing is done by the parent.

Reset
REQ-027 SHALL clear A, D and PC to 0 immediately when reset is low, independent of clk.
REQ-028 SHALL hold A, D and PC at 0 while reset is low, ignoring all load, increment and clear inputs.
REQ-029 SHALL resume normal operation on the first rising edge of clk after reset deasserts.
REQ-030 SHALL let the ALU outputs follow their inputs during reset, since the ALU holds no state.

Structure
REQ-031 SHALL place in a shared package: the WIDTH default, named bit positions for alu_ctrl, and named alu_ctrl constants (ADD=000010, AND=000000, X_MINUS_Y=010011, ZERO=101010, ONE=111111, NEG_ONE=111010).
REQ-032 SHALL implement the ALU as one combinational sub-module, hack_alu, and implement the registers and PC inline.

Verification
REQ-033 SHALL cover: alu_x=5, alu_y=3, alu_ctrl=ADD -> alu_out=8, zr=0, ng=0; alu_ctrl=X_MINUS_Y -> alu_out=2; alu_ctrl=AND -> alu_out=1.
REQ-034 SHALL cover: alu_ctrl=NEG_ONE -> alu_out=0xFFFF, ng=1, zr=0; alu_ctrl=ZERO -> alu_out=0, zr=1, ng=0; alu_x=0x7FFF, alu_y=1, ADD -> alu_out=0x8000, ng=1.
REQ-035 SHALL cover: a_in=0x1234 with a_load=1 for one edge, then a_load=0 with a_in=0xBEEF -> a_out stays 0x1234; d_load=1 in the same cycle loads D independently.
REQ-036 SHALL cover: pc_load=1 with pc_in=0x0010 -> 0x0010; then pc_inc=1 for 3 edges -> 0x0013; pc_load=1 with pc_in=0xFFFF, then pc_inc -> 0x0000.
REQ-037 SHALL cover: pc_clr=1, pc_load=1 and pc_inc=1 all high together -> PC=0; pc_load=1 and pc_inc=1 with pc_in=0x0040 -> PC=0x0040.
REQ-038 SHALL cover: reset driven low between clock edges with A=D=PC nonzero -> all three read 0 before the next edge and stay 0 while pc_inc=1; after release, the first edge with pc_inc=1 -> PC=1.
